fmul_pipe: RTL and testbench
============================

Name: fmul_pipe

Overview:
Parametrised, pipelined IEEE-754 binary floating-point multiplier for the FPU. It generalises the existing combinational single-precision multiplier in three ways: configurable exponent and mantissa widths, round-to-nearest-even with correct subnormal handling, and a 3-stage pipeline with valid/ready backpressure. It sits between the FPU issue logic and the FPU writeback mux and returns a result plus exception flags per accepted operation.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored mantissa width (hidden bit excluded)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair present
in_ready  out  1  block accepts operands this cycle
x1  in  1+EXP_W+MAN_W  operand 1 {sign, exp, man}
x2  in  1+EXP_W+MAN_W  operand 2
out_valid  out  1  result present
out_ready  in  1  consumer accepts result this cycle
y  out  1+EXP_W+MAN_W  product
ovf  out  1  overflow flag
udf  out  1  underflow flag (tiny and inexact)
nx  out  1  inexact flag
nv  out  1  invalid flag (inf*0 or signalling NaN input)

Behaviour:
- Clocking: one clock domain (clk); reset rst is synchronous and active-high. Reset clears all stage valid bits. The out_valid, y and all flags reset to 0. Reset mid-operation discards every in-flight operation; in_ready is 1 in the cycle after reset deasserts.
- Handshake: a transfer occurs on in_valid&&in_ready and on out_valid&&out_ready.
  - advance = ~out_valid | out_ready. All three stages shift together when advance=1 and all hold when advance=0.
  - in_ready = advance, a combinational function of out_valid and out_ready only. There is no combinational path from in_valid to in_ready.
  - Latency is exactly 3 cycles with no stall. Throughput is 1 per cycle.
  - Results leave in acceptance order. Bubbles propagate as valid=0 and are never exposed.
- Stage 1 (unpack/multiply):
  - Subnormal input (exp==0): hidden bit 0, effective exponent 1.
  - Classify zero, inf, qNaN and sNaN (NaN means exp all-ones with man!=0; sNaN has man MSB=0).
  - Sign = s1^s2.
  - Exponent sum e1+e2-bias, signed, EXP_W+2 bits.
  - Full (2*MAN_W+2)-bit mantissa product.
- Stage 2 (normalise):
  - Leading-zero count of the product; shift left to put the MSB at the top, adjusting the exponent.
  - If the adjusted exponent is < 1, shift right by (1-exp) and set exp=0 (subnormal path).
  - Shifted-out bits OR into sticky.
- Stage 3 (round/pack):
  - RNE on guard/round/sticky: increment if G&(R|S|LSB).
  - Mantissa carry-out increments the exponent; on the subnormal path it promotes to the minimum normal.
  - nx = G|R|S.
  - Exp >= all-ones after rounding gives ±inf with ovf=1, nx=1.
  - udf = result tiny before rounding && nx. An exact tiny result does not raise udf.
  - Exact zero keeps sign s1^s2.
- Specials (override, decided in stage 1 and carried as a tag):
  - Any NaN input gives the canonical qNaN {0, all-ones, 1, 0...}. nv=1 only if an input is sNaN.
  - inf*0 gives canonical qNaN with nv=1.
  - inf*finite-nonzero and inf*inf give ±inf with no flags.
  - Specials never set ovf, udf or nx.
- Flags are valid only with out_valid and are held stable while stalled.
- Output registers change only when advance=1.

Decomposition:
- Package fpu_pkg holds:
  - localparam helpers for bias, exponent all-ones and canonical NaN as functions of EXP_W and MAN_W;
  - typedef enum for operand class {ZERO, SUB, NORM, INF, QNAN, SNAN};
  - typedef struct for the flag bundle {nv, ovf, udf, nx}.
- One sub-module is natural: fpu_lzc, a parametrised leading-zero counter of width 2*MAN_W+2, used in stage 2 and reusable by fadd.

Test Plan:
1. Default params. 0x3FC00000 * 0x40000000, out_ready=1 → y=0x40400000 exactly 3 cycles later; all flags 0.
2. 0x3F800001 * 0x3F800001 → y=0x3F800002, nx=1, other flags 0. Also 0x7F7FFFFF * 0x40000000 → y=0x7F800000, ovf=1, nx=1.
3. Specials:
   - 0x7F800000 * 0x00000000 → 0x7FC00000, nv=1.
   - 0x7FA00000 (sNaN) * 0x3F800000 → 0x7FC00000, nv=1.
   - 0xFF800000 * 0x40000000 → 0xFF800000, no flags.
4. Subnormals:
   - 0x00800000 * 0x3F000000 → 0x00400000, udf=0, nx=0.
   - 0x00000001 * 0x3F000000 → 0x00000000 (tie rounds to even), udf=1, nx=1.
   - 0x80000003 * 0x3F000000 → 0x80000002, udf=1.
5. Backpressure: issue 6 back-to-back ops and hold out_ready=0 for cycles 4–8 → in_ready=0 while stalled, y and flags stable, all 6 results delivered in order with no loss or duplicates.
6. Assert rst for 1 cycle with 3 ops in flight → out_valid=0 the next cycle, none of the flushed results ever appears, and an op issued right after reset returns after 3 cycles. Also repeat case 1 at EXP_W=11, MAN_W=52: 0x3FF8000000000000 * 0x4000000000000000 → 0x4008000000000000.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU types and format helpers derived from exponent/mantissa widths
package fpu_pkg;
    typedef enum logic [2:0] {CL_ZERO, CL_SUB, CL_NORM, CL_INF, CL_QNAN, CL_SNAN} fp_class_e;
    typedef struct packed {
        logic nv;
        logic ovf;
        logic udf;
        logic nx;
    } fp_flags_t;
    function automatic int fp_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction
    function automatic int fp_exp_ones(input int ew);
        return (1 << ew) - 1;
    endfunction
    function automatic logic [127:0] fp_qnan(input int ew, input int mw);
        return ((128'd1 << (ew + 1)) - 128'd1) << (mw - 1);
    endfunction
    function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic man_zero, input logic man_msb);
        return exp_zero ? (man_zero ? CL_ZERO : CL_SUB) :
               !exp_ones ? CL_NORM :
               man_zero ? CL_INF :
               man_msb ? CL_QNAN : CL_SNAN;
    endfunction
endpackage

// File: rtl/fpu_lzc.sv
// fpu_lzc: leading-zero counter, returns W for an all-zero input
module fpu_lzc #(
    parameter int W = 48,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_a,
    output logic [CW-1:0] o_cnt
);
    always_comb begin
        o_cnt = CW'(W);
        for (int i = 0; i < W; i++) o_cnt = i_a[i] ? CW'(W - 1 - i) : o_cnt;
    end
endmodule

// File: rtl/fmul_pipe.sv
// fmul_pipe: 3-stage IEEE-754 multiplier, RNE with subnormals, valid/ready backpressure
module fmul_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     x1,
    input  logic [EXP_W+MAN_W:0]     x2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     y,
    output logic                     ovf,
    output logic                     udf,
    output logic                     nx,
    output logic                     nv
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int P  = 2 * MAN_W + 2;
    localparam int CW = $clog2(P + 1);
    localparam int XW = EXP_W + 2 + CW;
    localparam logic signed [EXP_W+1:0] BIAS = (EXP_W + 2)'(fp_bias(EXP_W));
    localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic signed [XW-1:0] EXP_MAX = XW'(fp_exp_ones(EXP_W));
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [CW-1:0] P_CW = CW'(P);

    logic w_adv;
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    fp_class_e w_c1, w_c2;
    logic w_s, w_nan, w_snan, w_inf, w_zero, w_spec, w_spec_nv;
    logic [W-1:0] w_spec_y;
    logic [EXP_W-1:0] w_e1, w_e2;
    logic [MAN_W:0] w_m1, w_m2;
    logic [P-1:0] w_prod;
    logic signed [EXP_W+1:0] w_esum;
    assign w_c1 = fp_classify(~|x1[MAN_W+:EXP_W], &x1[MAN_W+:EXP_W], ~|x1[MAN_W-1:0], x1[MAN_W-1]);
    assign w_c2 = fp_classify(~|x2[MAN_W+:EXP_W], &x2[MAN_W+:EXP_W], ~|x2[MAN_W-1:0], x2[MAN_W-1]);
    assign w_s       = x1[W-1] ^ x2[W-1];
    assign w_nan     = (w_c1 inside {CL_QNAN, CL_SNAN}) | (w_c2 inside {CL_QNAN, CL_SNAN});
    assign w_snan    = (w_c1 == CL_SNAN) | (w_c2 == CL_SNAN);
    assign w_inf     = (w_c1 == CL_INF) | (w_c2 == CL_INF);
    assign w_zero    = (w_c1 == CL_ZERO) | (w_c2 == CL_ZERO);
    // zero*finite is tagged too so the datapath never has to normalise a zero product
    assign w_spec    = w_nan | w_inf | w_zero;
    assign w_spec_nv = w_snan | (w_inf & w_zero);
    assign w_spec_y  = (w_nan | (w_inf & w_zero)) ? QNAN :
                       w_inf ? {w_s, EXP_ONES, MAN_W'(0)} : {w_s, (W - 1)'(0)};
    assign w_e1   = |x1[MAN_W+:EXP_W] ? x1[MAN_W+:EXP_W] : EXP_W'(1);
    assign w_e2   = |x2[MAN_W+:EXP_W] ? x2[MAN_W+:EXP_W] : EXP_W'(1);
    assign w_m1   = {|x1[MAN_W+:EXP_W], x1[MAN_W-1:0]};
    assign w_m2   = {|x2[MAN_W+:EXP_W], x2[MAN_W-1:0]};
    assign w_prod = P'(w_m1) * P'(w_m2);
    assign w_esum = $signed({2'b00, w_e1}) + $signed({2'b00, w_e2}) - BIAS;

    logic r1_valid, r1_spec, r1_spec_nv, r1_sign;
    logic [W-1:0] r1_spec_y;
    logic signed [EXP_W+1:0] r1_exp;
    logic [P-1:0] r1_prod;

    logic [CW-1:0] w_lz, w_shc;
    logic [P-1:0] w_mn;
    logic signed [XW-1:0] w_exp_a;
    logic [XW-1:0] w_sh;
    logic w_tiny;
    logic [2*P-1:0] w_wide;
    fpu_lzc #(.W(P)) u_lzc (.i_a(r1_prod), .o_cnt(w_lz));
    // product MSB sits at weight 2^1, hence the +1 before subtracting the shift
    assign w_mn    = r1_prod << w_lz;
    assign w_exp_a = {{(XW - EXP_W - 2){r1_exp[EXP_W+1]}}, r1_exp} + XW'(1) - XW'(w_lz);
    assign w_tiny  = w_exp_a[XW-1] | (w_exp_a == '0);
    assign w_sh    = XW'(1) - w_exp_a;
    assign w_shc   = w_tiny ? ((w_sh >= XW'(P)) ? P_CW : w_sh[CW-1:0]) : '0;
    assign w_wide  = {w_mn, {P{1'b0}}} >> w_shc;

    logic r2_valid, r2_spec, r2_spec_nv, r2_sign, r2_tiny, r2_sticky;
    logic [W-1:0] r2_spec_y;
    logic signed [XW-1:0] r2_exp;
    logic [P-2:0] r2_man;

    logic [MAN_W-1:0] w_frac;
    logic w_g, w_r, w_st, w_inc, w_ovf, w_nx;
    logic [XW+MAN_W-1:0] w_rnd;
    logic signed [XW-1:0] w_exp_r;
    logic [W-1:0] w_y;
    fp_flags_t w_flags, r_flags;
    assign w_frac  = r2_man[P-2 -: MAN_W];
    assign w_g     = r2_man[MAN_W];
    assign w_r     = r2_man[MAN_W-1];
    assign w_st    = |r2_man[MAN_W-2:0] | r2_sticky;
    assign w_inc   = w_g & (w_r | w_st | w_frac[0]);
    // a mantissa carry ripples into the exponent, which also promotes subnormals to min normal
    assign w_rnd   = {r2_exp, w_frac} + (XW + MAN_W)'(w_inc);
    assign w_exp_r = w_rnd[MAN_W+:XW];
    assign w_ovf   = w_exp_r >= EXP_MAX;
    assign w_nx    = w_g | w_r | w_st | w_ovf;
    assign w_y     = r2_spec ? r2_spec_y :
                     w_ovf ? {r2_sign, EXP_ONES, MAN_W'(0)} : {r2_sign, w_rnd[EXP_W+MAN_W-1:0]};
    assign w_flags = r2_spec ? {r2_spec_nv, 3'b000} : {1'b0, w_ovf, r2_tiny & w_nx, w_nx};

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid  <= 1'b0;
            r2_valid  <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            r_flags   <= '0;
        end else if (w_adv) begin
            r1_valid   <= in_valid;
            r1_spec    <= w_spec;
            r1_spec_nv <= w_spec_nv;
            r1_spec_y  <= w_spec_y;
            r1_sign    <= w_s;
            r1_exp     <= w_esum;
            r1_prod    <= w_prod;
            r2_valid   <= r1_valid;
            r2_spec    <= r1_spec;
            r2_spec_nv <= r1_spec_nv;
            r2_spec_y  <= r1_spec_y;
            r2_sign    <= r1_sign;
            r2_tiny    <= w_tiny;
            r2_exp     <= w_tiny ? '0 : w_exp_a;
            r2_man     <= w_wide[2*P-2:P];
            r2_sticky  <= |w_wide[P-1:0];
            out_valid  <= r2_valid;
            y          <= w_y;
            r_flags    <= w_flags;
        end
    end

    assign nv  = r_flags.nv;
    assign ovf = r_flags.ovf;
    assign udf = r_flags.udf;
    assign nx  = r_flags.nx;
endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: directed vectors for single and double precision multiplier pipelines
module tb_fmul_pipe;
    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [31:0] x1, x2, y;
    logic ovf, udf, nx, nv;
    logic [3:0] flags;
    logic d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [63:0] d_x1, d_x2, d_y;
    logic d_ovf, d_udf, d_nx, d_nv;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    assign flags = {nv, ovf, udf, nx};

    fmul_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x1(x1), .x2(x2),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf), .udf(udf), .nx(nx), .nv(nv)
    );
    fmul_pipe #(.EXP_W(11), .MAN_W(52)) dut_d (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .x1(d_x1), .x2(d_x2),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .y(d_y), .ovf(d_ovf), .udf(d_udf),
        .nx(d_nx), .nv(d_nv)
    );

    // flags column is {nv, ovf, udf, nx}
    logic [31:0] va [11] = '{32'h3FC00000, 32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h7FA00000,
                             32'hFF800000, 32'h00800000, 32'h00000001, 32'h80000003, 32'h7FC00001,
                             32'h80000000};
    logic [31:0] vb [11] = '{32'h40000000, 32'h3F800001, 32'h40000000, 32'h00000000, 32'h3F800000,
                             32'h40000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F800000,
                             32'h3F800000};
    logic [31:0] vy [11] = '{32'h40400000, 32'h3F800002, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
                             32'hFF800000, 32'h00400000, 32'h00000000, 32'h80000002, 32'h7FC00000,
                             32'h80000000};
    logic [3:0]  vf [11] = '{4'b0000, 4'b0001, 4'b0101, 4'b1000, 4'b1000, 4'b0000,
                             4'b0000, 4'b0011, 4'b0011, 4'b0000, 4'b0000};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic op_now(input int k);
        int cyc;
        in_valid = 1'b1;
        x1 = va[k];
        x2 = vb[k];
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("lat%0d", k), 64'(cyc), 64'd3);
        chk($sformatf("y%0d", k), 64'(y), 64'(vy[k]));
        chk($sformatf("flags%0d", k), 64'(flags), 64'(vf[k]));
    endtask

    task automatic run_op(input int k);
        @(negedge clk);
        op_now(k);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, issued, got, extra, cyc;
        logic [31:0] py;
        logic [3:0] pf;
        logic pstall;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x1 = '0;
        x2 = '0;
        d_in_valid = 1'b0;
        d_out_ready = 1'b1;
        d_x1 = '0;
        d_x2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);

        for (int k = 0; k < 11; k++) run_op(k);

        // six back-to-back ops with the consumer stalled for cycles 4..8
        c = 0;
        issued = 0;
        got = 0;
        pstall = 1'b0;
        py = '0;
        pf = '0;
        while (got < 6 && c < 60) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 8);
            in_valid = issued < 6;
            x1 = va[issued];
            x2 = vb[issued];
            #1;
            if (!out_ready && out_valid) begin
                chk("stall_ready", 64'(in_ready), 64'd0);
                if (pstall) begin
                    chk("stall_y", 64'(y), 64'(py));
                    chk("stall_flags", 64'(flags), 64'(pf));
                end
            end
            pstall = !out_ready && out_valid;
            py = y;
            pf = flags;
            if (in_valid && in_ready) issued++;
            if (out_valid && out_ready) begin
                chk($sformatf("bp_y%0d", got), 64'(y), 64'(vy[got]));
                chk($sformatf("bp_f%0d", got), 64'(flags), 64'(vf[got]));
                got++;
            end
            c++;
        end
        chk("bp_count", 64'(got), 64'd6);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("bp_extra", 64'(extra), 64'd0);

        // flush three in-flight ops with a one-cycle reset
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x1 = va[i];
            x2 = vb[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        op_now(5);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("flush_extra", 64'(extra), 64'd0);

        @(negedge clk);
        d_in_valid = 1'b1;
        d_x1 = 64'h3FF8000000000000;
        d_x2 = 64'h4000000000000000;
        @(negedge clk);
        d_in_valid = 1'b0;
        cyc = 1;
        while (!d_out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("dp_lat", 64'(cyc), 64'd3);
        chk("dp_y", d_y, 64'h4008000000000000);
        chk("dp_flags", 64'({d_nv, d_ovf, d_udf, d_nx}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
